// File: rtl/demux_pkg.sv
// Shared definitions for the stream demultiplexing router: default widths,
// the holding-register state encoding and the lane-select legality check.
package demux_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_N_OUT  = 4;
  localparam int DEF_SEL_W  = 2;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // A select addresses a real lane only when it is below the lane count;
  // wider select codes are accepted from upstream but then discarded.
  function automatic logic sel_is_legal(input int sel, input int n_out);
    return sel < n_out;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping to zero.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count increment requests, holding at the maximum once reached
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stream_demux_router.sv
// Registered 1-to-N stream demultiplexer. A single holding register carries
// the accepted word and its destination lane; readiness passes straight
// through from the selected consumer so a full register can be drained and
// refilled on the same edge. Per-lane transfer counts and an illegal-select
// drop count are kept in saturating counters.
module stream_demux_router
  import demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [SEL_W-1:0]       in_sel,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [N_OUT*CNT_W-1:0] lane_cnt,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   err_sel
);

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] hold_q;
  logic [SEL_W-1:0]  dst_q;
  logic              err_q;

  logic              accept;
  logic              legal;
  logic              load;
  logic              drop;
  logic              xfer;
  logic [N_OUT-1:0]  lane_inc;

  // Decode the held destination into a one-hot valid, only while a word is held
  always_comb begin
    out_valid = '0;
    for (int k = 0; k < N_OUT; k++) begin
      out_valid[k] = (state == FULL) && (dst_q == SEL_W'(k));
    end
  end

  assign lane_inc = out_valid & out_ready;
  assign xfer     = |lane_inc;
  assign in_ready = (state == EMPTY) || xfer;
  assign accept   = in_valid && in_ready;
  assign legal    = sel_is_legal(int'(in_sel), N_OUT);
  assign load     = accept && legal;
  assign drop     = accept && !legal;

  // Next-state: fill on a legal accept, empty when drained without a refill
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (load) state_next = FULL;
      FULL:    if (xfer && !load) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Holding register and destination; left untouched unless a legal word lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      dst_q  <= '0;
    end else if (load) begin
      hold_q <= in_data;
      dst_q  <= in_sel;
    end
  end

  // One-cycle error pulse following each dropped word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= drop;
    end
  end

  assign out_data = hold_q;
  assign err_sel  = err_q;

  for (genvar k = 0; k < N_OUT; k++) begin : g_lane_cnt
    sat_counter #(.W(CNT_W)) u_lane_cnt (
      .clk (clk),
      .rst (rst),
      .inc (lane_inc[k]),
      .cnt (lane_cnt[k*CNT_W +: CNT_W])
    );
  end

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .inc (drop),
    .cnt (drop_cnt)
  );

endmodule

// File: tb/tb_stream_demux_router.sv
// Bench for stream_demux_router. Two instances share the upstream stream:
// a default 4-lane / 8-bit-counter build and a 3-lane / 4-bit-counter build,
// so illegal selects and counter saturation both occur naturally.
module tb_stream_demux_router;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_ready;

  logic        in_ready_a;
  logic [3:0]  out_valid_a;
  logic [7:0]  out_data_a;
  logic [31:0] lane_cnt_a;
  logic [7:0]  drop_cnt_a;
  logic        err_sel_a;

  logic        in_ready_b;
  logic [2:0]  out_valid_b;
  logic [7:0]  out_data_b;
  logic [11:0] lane_cnt_b;
  logic [3:0]  drop_cnt_b;
  logic        err_sel_b;

  int total = 0;
  int bad   = 0;

  // Reference model: index 0 is the 4-lane build, index 1 the 3-lane build
  int          n_lanes [2] = '{4, 3};
  int          cnt_max [2] = '{255, 15};
  logic        m_full  [2];
  logic [7:0]  m_data  [2];
  int          m_dst   [2];
  int          m_lane  [2][4];
  int          m_drop  [2];
  logic        m_err   [2];

  stream_demux_router #(.DATA_W(8), .N_OUT(4), .SEL_W(2), .CNT_W(8)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_data  (out_data_a),
    .lane_cnt  (lane_cnt_a),
    .drop_cnt  (drop_cnt_a),
    .err_sel   (err_sel_a)
  );

  stream_demux_router #(.DATA_W(8), .N_OUT(3), .SEL_W(2), .CNT_W(4)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid_b),
    .out_ready (out_ready[2:0]),
    .out_data  (out_data_b),
    .lane_cnt  (lane_cnt_b),
    .drop_cnt  (drop_cnt_b),
    .err_sel   (err_sel_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    for (int m = 0; m < 2; m++) begin
      m_full[m] = 1'b0;
      m_data[m] = 8'h00;
      m_dst[m]  = 0;
      m_drop[m] = 0;
      m_err[m]  = 1'b0;
      for (int k = 0; k < 4; k++) m_lane[m][k] = 0;
    end
  endtask

  function automatic logic [3:0] expValid(input int m);
    return m_full[m] ? 4'(1 << m_dst[m]) : 4'b0000;
  endfunction

  function automatic logic expReady(input int m);
    return !m_full[m] || out_ready[m_dst[m]];
  endfunction

  // Compare every observable output of both instances with the model
  task automatic checkOutput();
    checkVal("a.in_ready",  32'(in_ready_a),  32'(expReady(0)));
    checkVal("a.out_valid", 32'(out_valid_a), 32'(expValid(0)));
    checkVal("a.out_data",  32'(out_data_a),  32'(m_data[0]));
    for (int k = 0; k < 4; k++)
      checkVal($sformatf("a.lane_cnt%0d", k), 32'(lane_cnt_a[k*8 +: 8]), 32'(m_lane[0][k]));
    checkVal("a.drop_cnt",  32'(drop_cnt_a),  32'(m_drop[0]));
    checkVal("a.err_sel",   32'(err_sel_a),   32'(m_err[0]));
    checkVal("b.in_ready",  32'(in_ready_b),  32'(expReady(1)));
    checkVal("b.out_valid", 32'(out_valid_b), 32'(expValid(1)));
    checkVal("b.out_data",  32'(out_data_b),  32'(m_data[1]));
    for (int k = 0; k < 3; k++)
      checkVal($sformatf("b.lane_cnt%0d", k), 32'(lane_cnt_b[k*4 +: 4]), 32'(m_lane[1][k]));
    checkVal("b.drop_cnt",  32'(drop_cnt_b),  32'(m_drop[1]));
    checkVal("b.err_sel",   32'(err_sel_b),   32'(m_err[1]));
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic modelStep();
    logic xfer;
    logic acc;
    logic legal;
    for (int m = 0; m < 2; m++) begin
      xfer  = m_full[m] && out_ready[m_dst[m]];
      acc   = in_valid && expReady(m);
      legal = int'(in_sel) < n_lanes[m];
      if (xfer) begin
        if (m_lane[m][m_dst[m]] < cnt_max[m]) m_lane[m][m_dst[m]]++;
        m_full[m] = 1'b0;
      end
      if (acc && legal) begin
        m_full[m] = 1'b1;
        m_data[m] = in_data;
        m_dst[m]  = int'(in_sel);
      end
      m_err[m] = acc && !legal;
      if (m_err[m] && (m_drop[m] < cnt_max[m])) m_drop[m]++;
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then take the edge
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [1:0] s,
                               input logic [3:0] r);
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    out_ready = r;
    #1;
    checkOutput();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] stream_demux_router bench start");
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_sel    = 2'd0;
    out_ready = 4'h0;
    resetModel();
    #2;
    checkOutput();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single word to lane 2
    applyStimulus(1'b0, 8'h00, 2'd0, 4'hF);
    applyStimulus(1'b1, 8'hA5, 2'd2, 4'hF);
    in_valid = 1'b0;
    #1;
    checkVal("plan.single_valid", 32'(out_valid_a), 32'h4);
    checkVal("plan.single_data",  32'(out_data_a),  32'hA5);
    applyStimulus(1'b0, 8'h00, 2'd0, 4'hF);
    checkVal("plan.single_cnt2", 32'(lane_cnt_a[23:16]), 32'd1);
    applyStimulus(1'b0, 8'h00, 2'd0, 4'hF);

    // Lane 1 stalled for five cycles with the next word waiting
    applyStimulus(1'b1, 8'h3C, 2'd1, 4'hF);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h77, 2'd3, 4'b1101);
    checkVal("plan.stall_valid", 32'(out_valid_a), 32'h2);
    checkVal("plan.stall_data",  32'(out_data_a),  32'h3C);
    applyStimulus(1'b1, 8'h77, 2'd3, 4'hF);
    applyStimulus(1'b0, 8'h00, 2'd0, 4'hF);

    // Back-to-back streaming through lanes 0..3
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(16 + i), 2'(i % 4), 4'hF);
    applyStimulus(1'b0, 8'h00, 2'd0, 4'hF);

    // Lane 3 is illegal on the 3-lane build
    applyStimulus(1'b1, 8'hFF, 2'd3, 4'hF);
    applyStimulus(1'b0, 8'h00, 2'd0, 4'hF);
    applyStimulus(1'b0, 8'h00, 2'd0, 4'hF);

    // Twenty transfers to lane 0 drive the 4-bit counter into saturation
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(i * 3), 2'd0, 4'hF);
    applyStimulus(1'b0, 8'h00, 2'd0, 4'hF);
    applyStimulus(1'b0, 8'h00, 2'd0, 4'hF);
    checkVal("plan.sat_b_lane0", 32'(lane_cnt_b[3:0]), 32'd15);

    // Randomised traffic
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(1, 0)), 8'($urandom), 2'($urandom_range(3, 0)),
                    4'($urandom));

    // Asynchronous reset while a word is stalled on lane 2
    applyStimulus(1'b1, 8'h5A, 2'd2, 4'b1011);
    applyStimulus(1'b0, 8'h00, 2'd0, 4'b1011);
    #2;
    rst = 1'b1;
    #1;
    resetModel();
    checkVal("areset.a_valid", 32'(out_valid_a), 32'h0);
    checkVal("areset.b_valid", 32'(out_valid_b), 32'h0);
    checkVal("areset.a_cnt",   lane_cnt_a,       32'h0);
    checkVal("areset.b_cnt",   32'(lane_cnt_b),  32'h0);
    checkVal("areset.a_drop",  32'(drop_cnt_a),  32'h0);
    checkVal("areset.b_drop",  32'(drop_cnt_b),  32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 8'hC3, 2'd1, 4'hF);
    applyStimulus(1'b0, 8'h00, 2'd0, 4'hF);
    applyStimulus(1'b0, 8'h00, 2'd0, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
